// File: rtl/decode_exec_stage_pkg.sv
// Shared constants for the decode/execute boundary of the VeSPA pipeline.
// Register file select encodings and stage FSM state codes.
package decode_exec_stage_pkg;

  localparam int REG_FILE_MSB = 4;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_REG_AW   = REG_FILE_MSB + 1;
  localparam int DEF_OPC_W    = 5;
  localparam int DEF_CNT_W    = 16;

  localparam logic [1:0] RF_SEL_PC   = 2'b00;
  localparam logic [1:0] RF_SEL_LOAD = 2'b01;
  localparam logic [1:0] RF_SEL_ALU  = 2'b10;
  localparam logic [1:0] RF_SEL_LDI  = 2'b11;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } stage_state_e;

endpackage

// File: rtl/decode_exec_stage_load_use_detector.sv
// Load-use hazard compare between the EX load and the decode sources.
// Register r0 is compared like any other register.
module load_use_detector
  import decode_exec_stage_pkg::*;
#(
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic              exValid,
  input  logic              exRfWe,
  input  logic [1:0]        exRfInSel,
  input  logic [REG_AW-1:0] exRdAddr,
  input  logic              decValid,
  input  logic [REG_AW-1:0] decRs1Addr,
  input  logic [REG_AW-1:0] decRs2Addr,
  input  logic              decUsesRs1,
  input  logic              decUsesRs2,
  output logic              hazard
);

  logic exIsLoad;
  logic rs1Hit;
  logic rs2Hit;

  assign exIsLoad = exValid & exRfWe
                  & (exRfInSel == RF_SEL_LOAD);
  assign rs1Hit = decUsesRs1
                & (decRs1Addr == exRdAddr);
  assign rs2Hit = decUsesRs2
                & (decRs2Addr == exRdAddr);
  assign hazard = exIsLoad & decValid
                & (rs1Hit | rs2Hit);

endmodule

// File: rtl/decode_exec_stage.sv
// ID/EX pipeline register with load-use stall, branch flush
// and saturating stall/flush event counters.
module decode_exec_stage
  import decode_exec_stage_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_AW = DEF_REG_AW,
  parameter int OPC_W  = DEF_OPC_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              i_Clk,
  input  logic              i_Rst_n,
  input  logic              i_DecValid,
  input  logic [REG_AW-1:0] i_DecRs1Addr,
  input  logic [REG_AW-1:0] i_DecRs2Addr,
  input  logic              i_DecUsesRs1,
  input  logic              i_DecUsesRs2,
  input  logic [REG_AW-1:0] i_DecRdAddr,
  input  logic              i_DecRfWe,
  input  logic [1:0]        i_DecRfInSel,
  input  logic              i_DecMemRe,
  input  logic              i_DecMemWe,
  input  logic [OPC_W-1:0]  i_DecAluOp,
  input  logic [DATA_W-1:0] i_DecOp1Data,
  input  logic [DATA_W-1:0] i_DecOp2Data,
  input  logic [DATA_W-1:0] i_DecImm,
  input  logic [DATA_W-1:0] i_DecPc,
  input  logic              i_FlushExec,
  input  logic              i_Hold,
  output logic              o_ExValid,
  output logic [REG_AW-1:0] o_IrRead1AddrDecodeExec,
  output logic [REG_AW-1:0] o_IrRead2AddrDecodeExec,
  output logic [REG_AW-1:0] o_ExRdAddr,
  output logic              o_ExRfWe,
  output logic [1:0]        o_ExRfInSel,
  output logic              o_ExMemRe,
  output logic              o_ExMemWe,
  output logic [OPC_W-1:0]  o_ExAluOp,
  output logic [DATA_W-1:0] o_ExOp1Data,
  output logic [DATA_W-1:0] o_ExOp2Data,
  output logic [DATA_W-1:0] o_ExImm,
  output logic [DATA_W-1:0] o_ExPc,
  output logic              o_StallFetchDecode,
  output logic [CNT_W-1:0]  o_StallCount,
  output logic [CNT_W-1:0]  o_FlushCount
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic              rfWe;
    logic [1:0]        rfInSel;
    logic              memRe;
    logic              memWe;
    logic [OPC_W-1:0]  aluOp;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc;
  } id_ex_t;

  id_ex_t       ex;
  id_ex_t       exNext;
  id_ex_t       decIn;
  stage_state_e state;
  stage_state_e stateNext;
  logic         hazard;
  logic         stall;
  logic         holdEff;
  logic         loadDec;
  logic [CNT_W-1:0] stallCnt;
  logic [CNT_W-1:0] flushCnt;

  load_use_detector #(
    .REG_AW(REG_AW)
  ) u_detect (
    .exValid   (ex.valid),
    .exRfWe    (ex.rfWe),
    .exRfInSel (ex.rfInSel),
    .exRdAddr  (ex.rd),
    .decValid  (i_DecValid),
    .decRs1Addr(i_DecRs1Addr),
    .decRs2Addr(i_DecRs2Addr),
    .decUsesRs1(i_DecUsesRs1),
    .decUsesRs2(i_DecUsesRs2),
    .hazard    (hazard)
  );

  assign stall = hazard & ~i_FlushExec & ~i_Hold
               & (state == RUN);
  assign holdEff = i_Hold & ~i_FlushExec;
  assign loadDec = ~i_FlushExec & ~i_Hold & ~stall;

  always_comb begin
    decIn         = '0;
    decIn.valid   = 1'b1;
    decIn.rs1     = i_DecRs1Addr;
    decIn.rs2     = i_DecRs2Addr;
    decIn.rd      = i_DecRdAddr;
    decIn.rfWe    = i_DecRfWe;
    decIn.rfInSel = i_DecRfInSel;
    decIn.memRe   = i_DecMemRe;
    decIn.memWe   = i_DecMemWe;
    decIn.aluOp   = i_DecAluOp;
    decIn.op1     = i_DecOp1Data;
    decIn.op2     = i_DecOp2Data;
    decIn.imm     = i_DecImm;
    decIn.pc      = i_DecPc;
  end

  always_comb begin
    exNext = ex;
    unique case (1'b1)
      i_FlushExec: exNext = '0;
      holdEff:     exNext = ex;
      stall:       exNext = '0;
      loadDec:     exNext = i_DecValid ? decIn : '0;
      default:     exNext = ex;
    endcase
  end

  // The bubble in EX rules out a hazard in STALL; only hold keeps it.
  always_comb begin
    stateNext = state;
    unique case (state)
      RUN:     if (stall)   stateNext = STALL;
      STALL:   if (!i_Hold) stateNext = RUN;
      default: stateNext = RUN;
    endcase
    if (i_FlushExec) stateNext = RUN;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      ex       <= '0;
      state    <= RUN;
      stallCnt <= '0;
      flushCnt <= '0;
    end else begin
      ex    <= exNext;
      state <= stateNext;
      if (i_FlushExec && flushCnt != '1)
        flushCnt <= flushCnt + 1'b1;
      if (stall && stallCnt != '1)
        stallCnt <= stallCnt + 1'b1;
    end
  end

  assign o_ExValid               = ex.valid;
  assign o_IrRead1AddrDecodeExec = ex.rs1;
  assign o_IrRead2AddrDecodeExec = ex.rs2;
  assign o_ExRdAddr              = ex.rd;
  assign o_ExRfWe                = ex.rfWe;
  assign o_ExRfInSel             = ex.rfInSel;
  assign o_ExMemRe               = ex.memRe;
  assign o_ExMemWe               = ex.memWe;
  assign o_ExAluOp               = ex.aluOp;
  assign o_ExOp1Data             = ex.op1;
  assign o_ExOp2Data             = ex.op2;
  assign o_ExImm                 = ex.imm;
  assign o_ExPc                  = ex.pc;
  assign o_StallFetchDecode      = stall;
  assign o_StallCount            = stallCnt;
  assign o_FlushCount            = flushCnt;

endmodule

// File: tb/tb_decode_exec_stage.sv
// Scoreboard bench for decode_exec_stage: directed decode vectors,
// expected EX contents queued per cycle and checked by a monitor.
module tb_decode_exec_stage;

  typedef struct packed {
    logic        v;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        u1;
    logic        u2;
    logic [4:0]  rd;
    logic        we;
    logic [1:0]  sel;
    logic        re;
    logic        mwe;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [31:0] pc;
  } ins_t;

  typedef struct {
    logic        st;
    ins_t        ex;
    logic [15:0] sc;
    logic [15:0] fc;
    logic [5:0]  ssc;
  } rec_t;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  logic flush = 1'b0;
  logic hold = 1'b0;
  ins_t d = '0;

  logic        exV, exWe, exRe, exMwe, stl;
  logic [4:0]  r1, r2, rd, op;
  logic [1:0]  sel;
  logic [31:0] a, b, imm, pc;
  logic [15:0] sc, fc;

  logic        sV, sWe, sRe, sMwe, sStl;
  logic [4:0]  sR1, sR2, sRd, sOp;
  logic [1:0]  sSel;
  logic [31:0] sA, sB, sImm, sPc;
  logic [5:0]  sSc, sFc;

  rec_t q[$];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  decode_exec_stage dut (
    .i_Clk(clk), .i_Rst_n(rstN),
    .i_DecValid(d.v),
    .i_DecRs1Addr(d.rs1), .i_DecRs2Addr(d.rs2),
    .i_DecUsesRs1(d.u1), .i_DecUsesRs2(d.u2),
    .i_DecRdAddr(d.rd), .i_DecRfWe(d.we),
    .i_DecRfInSel(d.sel),
    .i_DecMemRe(d.re), .i_DecMemWe(d.mwe),
    .i_DecAluOp(d.op),
    .i_DecOp1Data(d.a), .i_DecOp2Data(d.b),
    .i_DecImm(d.imm), .i_DecPc(d.pc),
    .i_FlushExec(flush), .i_Hold(hold),
    .o_ExValid(exV),
    .o_IrRead1AddrDecodeExec(r1),
    .o_IrRead2AddrDecodeExec(r2),
    .o_ExRdAddr(rd), .o_ExRfWe(exWe),
    .o_ExRfInSel(sel),
    .o_ExMemRe(exRe), .o_ExMemWe(exMwe),
    .o_ExAluOp(op),
    .o_ExOp1Data(a), .o_ExOp2Data(b),
    .o_ExImm(imm), .o_ExPc(pc),
    .o_StallFetchDecode(stl),
    .o_StallCount(sc), .o_FlushCount(fc)
  );

  decode_exec_stage #(.CNT_W(6)) dutS (
    .i_Clk(clk), .i_Rst_n(rstN),
    .i_DecValid(d.v),
    .i_DecRs1Addr(d.rs1), .i_DecRs2Addr(d.rs2),
    .i_DecUsesRs1(d.u1), .i_DecUsesRs2(d.u2),
    .i_DecRdAddr(d.rd), .i_DecRfWe(d.we),
    .i_DecRfInSel(d.sel),
    .i_DecMemRe(d.re), .i_DecMemWe(d.mwe),
    .i_DecAluOp(d.op),
    .i_DecOp1Data(d.a), .i_DecOp2Data(d.b),
    .i_DecImm(d.imm), .i_DecPc(d.pc),
    .i_FlushExec(flush), .i_Hold(hold),
    .o_ExValid(sV),
    .o_IrRead1AddrDecodeExec(sR1),
    .o_IrRead2AddrDecodeExec(sR2),
    .o_ExRdAddr(sRd), .o_ExRfWe(sWe),
    .o_ExRfInSel(sSel),
    .o_ExMemRe(sRe), .o_ExMemWe(sMwe),
    .o_ExAluOp(sOp),
    .o_ExOp1Data(sA), .o_ExOp2Data(sB),
    .o_ExImm(sImm), .o_ExPc(sPc),
    .o_StallFetchDecode(sStl),
    .o_StallCount(sSc), .o_FlushCount(sFc)
  );

  function automatic ins_t mk(
    input logic [4:0] rs1, input logic [4:0] rs2,
    input logic u1, input logic u2,
    input logic [4:0] rdA, input logic we,
    input logic [1:0] s, input logic re,
    input logic mwe, input logic [4:0] o,
    input logic [31:0] x, input logic [31:0] y,
    input logic [31:0] im, input logic [31:0] p);
    ins_t r;
    r = '{1'b1, rs1, rs2, u1, u2, rdA, we, s,
          re, mwe, o, x, y, im, p};
    return r;
  endfunction

  function automatic logic [25:0] ctl(input ins_t x);
    return {x.v, x.rs1, x.rs2, x.rd, x.we,
            x.sel, x.re, x.mwe, x.op};
  endfunction

  function automatic logic [127:0] dat(input ins_t x);
    return {x.a, x.b, x.imm, x.pc};
  endfunction

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h want=%0h",
               nm, $time, act, exp);
    end
  endtask

  task automatic cyc(input ins_t di, input logic fl,
                     input logic ho, input logic rn,
                     input logic st, input ins_t ex,
                     input int scE, input int fcE);
    rec_t r;
    @(negedge clk);
    rstN  = rn;
    d     = di;
    flush = fl;
    hold  = ho;
    r.st  = st;
    r.ex  = ex;
    r.sc  = 16'(scE);
    r.fc  = 16'(fcE);
    r.ssc = (scE > 63) ? 6'd63 : 6'(scE);
    q.push_back(r);
  endtask

  initial begin : monitor
    rec_t r;
    forever begin
      @(negedge clk);
      #3;
      if (q.size() != 0) begin
        r = q.pop_front();
        chk("stall", 128'(stl), 128'(r.st));
        @(posedge clk);
        #1;
        chk("exCtl",
            128'({exV, r1, r2, rd, exWe, sel,
                  exRe, exMwe, op}),
            128'(ctl(r.ex)));
        chk("exData", {a, b, imm, pc}, dat(r.ex));
        chk("counts", 128'({sc, fc}),
            128'({r.sc, r.fc}));
        chk("satCount", 128'(sSc), 128'(r.ssc));
      end
    end
  end

  initial begin : stim
    ins_t nop, add3, ld4, add5, addB, ld7;
    ins_t add8, st9, inv, ld0, use0, ldX, rnd;
    logic [159:0] raw;
    nop  = '0;
    add3 = mk(1, 2, 1, 1, 3, 1, 2'b10, 0, 0, 1,
              5, 7, 0, 32'h100);
    ld4  = mk(2, 0, 1, 0, 4, 1, 2'b01, 1, 0, 0,
              32'h40, 0, 8, 32'h104);
    add5 = mk(4, 1, 1, 1, 5, 1, 2'b10, 0, 0, 1,
              32'h11, 32'h22, 0, 32'h108);
    addB = mk(1, 4, 1, 0, 6, 1, 2'b10, 0, 0, 2,
              32'h33, 32'h44, 0, 32'h10c);
    ld7  = mk(4, 0, 1, 0, 7, 1, 2'b01, 1, 0, 0,
              32'h50, 0, 4, 32'h110);
    add8 = mk(7, 3, 1, 1, 8, 1, 2'b10, 0, 0, 1,
              1, 2, 0, 32'h114);
    st9  = mk(8, 5, 1, 1, 0, 0, 2'b00, 0, 1, 0,
              32'h70, 32'h71, 12, 32'h118);
    inv  = add3;
    inv.v = 1'b0;
    ld0  = mk(3, 0, 1, 0, 0, 1, 2'b01, 1, 0, 0,
              32'h80, 0, 0, 32'h120);
    use0 = mk(0, 2, 1, 1, 9, 1, 2'b10, 0, 0, 3,
              32'h90, 32'h91, 0, 32'h124);
    ldX  = mk(4, 0, 1, 0, 4, 1, 2'b01, 1, 0, 0,
              32'h60, 0, 0, 32'h200);

    for (int i = 0; i < 4; i++) begin
      raw = {$urandom(), $urandom(), $urandom(),
             $urandom(), $urandom()};
      rnd = raw[155:0];
      cyc(rnd, 1'($urandom()), 1'($urandom()), 0,
          0, nop, 0, 0);
    end
    cyc(add3, 0, 0, 1, 0, add3, 0, 0);
    cyc(ld4,  0, 0, 1, 0, ld4,  0, 0);
    cyc(add5, 0, 0, 1, 1, nop,  1, 0);
    cyc(add5, 0, 0, 1, 0, add5, 1, 0);
    cyc(ld4,  0, 0, 1, 0, ld4,  1, 0);
    cyc(addB, 0, 0, 1, 0, addB, 1, 0);
    cyc(ld4,  0, 0, 1, 0, ld4,  1, 0);
    cyc(add5, 1, 0, 1, 0, nop,  1, 1);
    cyc(ld4,  0, 0, 1, 0, ld4,  1, 1);
    cyc(add5, 0, 0, 1, 1, nop,  2, 1);
    for (int i = 0; i < 3; i++)
      cyc(add5, 0, 1, 1, 0, nop, 2, 1);
    cyc(add5, 0, 0, 1, 0, add5, 2, 1);
    cyc(ld4,  0, 0, 1, 0, ld4,  2, 1);
    cyc(ld7,  0, 0, 1, 1, nop,  3, 1);
    cyc(ld7,  0, 0, 1, 0, ld7,  3, 1);
    cyc(add8, 0, 0, 1, 1, nop,  4, 1);
    cyc(add8, 0, 0, 1, 0, add8, 4, 1);
    cyc(st9,  0, 0, 1, 0, st9,  4, 1);
    cyc(ld4,  0, 1, 1, 0, st9,  4, 1);
    cyc(inv,  0, 0, 1, 0, nop,  4, 1);
    cyc(ld0,  0, 0, 1, 0, ld0,  4, 1);
    cyc(use0, 0, 0, 1, 1, nop,  5, 1);
    cyc(use0, 0, 0, 1, 0, use0, 5, 1);
    cyc(ld4,  0, 0, 1, 0, ld4,  5, 1);
    cyc(add5, 0, 0, 0, 0, nop,  0, 0);
    cyc(add5, 0, 0, 1, 0, add5, 0, 0);
    cyc(ldX,  0, 0, 1, 0, ldX,  0, 0);
    for (int i = 1; i <= 69; i++) begin
      cyc(ldX, 0, 0, 1, 1, nop, i, 0);
      cyc(ldX, 0, 0, 1, 0, ldX, i, 0);
    end
    cyc(nop, 0, 0, 1, 0, nop, 69, 0);

    repeat (4) @(posedge clk);
    #2;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
